axis_cpu_code_loader: RTL
=========================

# axis_cpu_code_loader

- Writes a program into the axis_cpu instruction memory from an AXI-Stream of 8-bit instruction bytes.
- It is the write side of the same code memory that the controller's fetch stage reads via `inst_rd_en`/`instr_in`.
- It holds the CPU while a load is in progress, then releases and starts it.
- It reports the program length and any load errors.

## Interface
Parameters:
- `CODE_ADDR_WIDTH`, default 10: code memory address width. Capacity is 2^CODE_ADDR_WIDTH bytes.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset. Synchronous, active-low: registers reset on a rising `clk` edge while `rst`=0.
- `prog_TDATA`  in  8  program byte.
- `prog_TVALID`  in  1  byte valid.
- `prog_TLAST`  in  1  last byte of the program.
- `prog_TREADY`  out  1  loader accepts a byte.
- `cpu_idle`  in  1  CPU has no packet in flight; a load may start.
- `code_wr_en`  out  1  code memory write strobe.
- `code_wr_addr`  out  CODE_ADDR_WIDTH  write address.
- `code_wr_data`  out  8  write data.
- `cpu_hold`  out  1  holds the CPU pipeline in reset; level signal.
- `cpu_start`  out  1  one-cycle pulse after a successful load.
- `prog_len`  out  CODE_ADDR_WIDTH+1  bytes written by the last load.
- `err_ovf`  out  1  sticky: the program exceeded capacity.
- `err_csum`  out  1  sticky checksum mismatch; only present when `LOADER_CHECKSUM_EN` is defined, otherwise tied to 0.

## Operation
- The FSM has three states: IDLE, LOAD, DONE.
- Reset values:
  - state IDLE; `cpu_hold`=1, because no valid program exists yet.
  - `cpu_start`, `code_wr_en`, `code_wr_addr`, `code_wr_data`, `prog_len`, `err_ovf`, `err_csum` are all 0.
  - `prog_TREADY`=0.
- IDLE:
  - `prog_TREADY` = `cpu_idle`.
  - On a handshake, go to LOAD.
  - On the same handshake: set `cpu_hold`=1, clear both error flags, set the write counter `cnt` (CODE_ADDR_WIDTH+1 bits) to 0, then process the beat as described under LOAD.
- LOAD:
  - `prog_TREADY`=1 unconditionally; the memory write never stalls.
  - On each handshake with `cnt` < 2^CODE_ADDR_WIDTH: issue a write at `addr`=`cnt[CODE_ADDR_WIDTH-1:0]`, then increment `cnt`.
  - On a handshake with `cnt` = 2^CODE_ADDR_WIDTH: drop the byte, set `err_ovf`, leave `cnt` unchanged (saturates).
  - The TLAST handshake goes to DONE.
  - If TLAST and `cnt` = 2^CODE_ADDR_WIDTH−1 arrive on the same beat, the byte is written and no overflow is flagged.
- DONE, one cycle:
  - `prog_len`←`cnt`.
  - The load succeeds if `err_ovf`=0, `err_csum`=0 and `cnt`≠0. On success, pulse `cpu_start` and set `cpu_hold`=0.
  - On failure, `cpu_hold` stays 1 and there is no `cpu_start`.
  - Next state is IDLE.
- `cpu_idle` is sampled only in IDLE. Once LOAD begins, it is ignored.
- If reset is asserted mid-load, the load is abandoned: all outputs return to their reset values, and memory contents already written stay undefined for use.

## Timing
- A byte accepted at cycle N produces `code_wr_en`=1 with its address and data at cycle N+1, all registered.
- For a TLAST handshake at cycle N:
  - the last write happens at N+1, and state is DONE at N+1;
  - `cpu_start` pulses and `cpu_hold` falls at N+2;
  - `prog_TREADY` = `cpu_idle` again at N+2.
- `prog_TREADY` is registered-free: combinational from state and `cpu_idle`.
- `cpu_hold` rises at cycle N+1 after the first handshake at N. The CPU therefore never fetches from a partially written image.
- Throughput is one byte per cycle, with no bubbles inside a program.
- There is one dead cycle (DONE) between programs.

## Configuration
- Macro: `LOADER_CHECKSUM_EN`.
- Defined:
  - The TLAST beat is a checksum byte and is not written to memory.
  - An 8-bit running sum covers every accepted beat, including the checksum, modulo 256.
  - A nonzero final sum sets `err_csum` in DONE, and the load fails.
  - A one-beat packet gives `prog_len`=0 and fails.
  - Overflow counting excludes the checksum beat.
- Undefined: the TLAST beat is an ordinary instruction byte, and `err_csum` is constant 0.

## Test plan
- Reset with `rst`=0 for 2 cycles → `cpu_hold`=1, all other outputs 0, `prog_TREADY`=0 while `cpu_idle`=0.
- `cpu_idle`=1; stream 0x11, 0x22, 0x33 with TLAST on 0x33, no macro:
  - writes (0,0x11), (1,0x22), (2,0x33) on consecutive cycles;
  - `prog_len`=3;
  - `cpu_start` pulses 2 cycles after TLAST;
  - `cpu_hold`=0.
- `CODE_ADDR_WIDTH`=2; stream 6 bytes with TLAST on the 6th:
  - writes to addresses 0–3 only;
  - `err_ovf`=1, `prog_len`=4;
  - no `cpu_start`, `cpu_hold` stays 1.
- `cpu_idle`=0 with `prog_TVALID`=1 → `prog_TREADY`=0 and no writes. Raise `cpu_idle` → the load starts the same cycle.
- With `LOADER_CHECKSUM_EN`:
  - stream 0x01, 0x02, 0xFD(TLAST) → 2 writes, `prog_len`=2, `cpu_start` pulses.
  - repeat with last byte 0xFE → `err_csum`=1 and no `cpu_start`.
- Assert `rst`=0 midway through a 10-byte load → next cycle: IDLE, `cpu_hold`=1, `code_wr_en`=0, `prog_len`=0.

Source files
------------

// File: rtl/axis_cpu_code_loader.sv
// AXI-Stream loader that writes 8-bit instruction bytes into the axis_cpu code memory
// and holds/starts the CPU. Optional checksum trailer byte: define LOADER_CHECKSUM_EN.
module axis_cpu_code_loader #(
   parameter int unsigned CODE_ADDR_WIDTH = 10
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [7:0]                 prog_TDATA,
   input  logic                       prog_TVALID,
   input  logic                       prog_TLAST,
   output logic                       prog_TREADY,
   input  logic                       cpu_idle,
   output logic                       code_wr_en,
   output logic [CODE_ADDR_WIDTH-1:0] code_wr_addr,
   output logic [7:0]                 code_wr_data,
   output logic                       cpu_hold,
   output logic                       cpu_start,
   output logic [CODE_ADDR_WIDTH:0]   prog_len,
   output logic                       err_ovf,
   output logic                       err_csum
);

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   localparam logic [CODE_ADDR_WIDTH:0] CAP = {1'b1, {CODE_ADDR_WIDTH{1'b0}}};

   state_t                     state_q;
   logic [CODE_ADDR_WIDTH:0]   cnt_q, cnt_d, cnt_base;
   logic                       wr_en_q;
   logic [CODE_ADDR_WIDTH-1:0] wr_addr_q;
   logic [7:0]                 wr_data_q;
   logic                       hold_q, start_q;
   logic [CODE_ADDR_WIDTH:0]   len_q;
   logic                       ovf_q, ovf_d, ovf_base;
   logic                       hs, is_data, full, do_wr, load_ok;

   assign prog_TREADY = (state_q == IDLE) ? cpu_idle : (state_q == LOAD);
   assign hs          = prog_TVALID & prog_TREADY;

`ifdef LOADER_CHECKSUM_EN
   logic [7:0] sum_q, sum_d;
   logic       csum_q;
   assign is_data  = ~prog_TLAST;
   assign err_csum = csum_q;
`else
   assign is_data  = 1'b1;
   assign err_csum = 1'b0;
`endif

   // The first beat is taken in IDLE, so it starts from a freshly cleared count/flags.
   always_comb begin
      cnt_base = (state_q == IDLE) ? '0 : cnt_q;
      ovf_base = (state_q == IDLE) ? 1'b0 : ovf_q;
      full     = (cnt_base == CAP);
      do_wr    = hs & is_data & ~full;
      cnt_d    = do_wr ? cnt_base + 1'b1 : cnt_base;
      ovf_d    = ovf_base | (hs & is_data & full);
`ifdef LOADER_CHECKSUM_EN
      sum_d    = ((state_q == IDLE) ? 8'h00 : sum_q) + (hs ? prog_TDATA : 8'h00);
      load_ok  = ~ovf_q & (cnt_q != '0) & (sum_q == 8'h00);
`else
      load_ok  = ~ovf_q & (cnt_q != '0);
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         hold_q    <= 1'b1;
         start_q   <= 1'b0;
         len_q     <= '0;
         ovf_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         sum_q     <= '0;
         csum_q    <= 1'b0;
`endif
      end else begin
         wr_en_q <= 1'b0;
         start_q <= 1'b0;
         case (state_q)
            IDLE, LOAD: begin
               if (hs) begin
                  hold_q  <= 1'b1;
                  cnt_q   <= cnt_d;
                  ovf_q   <= ovf_d;
                  wr_en_q <= do_wr;
                  if (do_wr) begin
                     wr_addr_q <= cnt_base[CODE_ADDR_WIDTH-1:0];
                     wr_data_q <= prog_TDATA;
                  end
`ifdef LOADER_CHECKSUM_EN
                  sum_q <= sum_d;
                  if (state_q == IDLE) csum_q <= 1'b0;
`endif
                  state_q <= prog_TLAST ? DONE : LOAD;
               end
            end
            DONE: begin
               len_q   <= cnt_q;
               start_q <= load_ok;
               hold_q  <= ~load_ok;
`ifdef LOADER_CHECKSUM_EN
               csum_q  <= (sum_q != 8'h00);
`endif
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign code_wr_en   = wr_en_q;
   assign code_wr_addr = wr_addr_q;
   assign code_wr_data = wr_data_q;
   assign cpu_hold     = hold_q;
   assign cpu_start    = start_q;
   assign prog_len     = len_q;
   assign err_ovf      = ovf_q;

endmodule
